debug_ram_wr_arbiter: RTL and testbench



---
 rtl/debug_ram_pkg.sv | 12 +
 rtl/rr_pick.sv | 24 ++
 rtl/debug_ram_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_debug_ram_wr_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_ram_pkg.sv
// Shared constants and arbiter state encoding for the debug RAM write path.
package debug_ram_pkg;

  localparam int DEBUG_RAM_ADDR_W = 10;
  localparam int DEBUG_RAM_DATA_W = 8;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    winner = '0;
    any    = |req;
    idx    = '0;
    // Walk from the farthest offset back to ptr so the nearest request wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr) + k) % N_REQ);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/debug_ram_wr_arbiter.sv
// Round-robin burst arbiter sharing the debug RAM write port A among producers.
module debug_ram_wr_arbiter
  import debug_ram_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int ADDR_W    = DEBUG_RAM_ADDR_W,
  parameter int DATA_W    = DEBUG_RAM_DATA_W,
  parameter int MAX_BURST = 16,
  parameter int STALL_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ-1:0]           req_last,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic                       ram_en,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [DATA_W-1:0]          ram_data,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int BEAT_W  = $clog2(MAX_BURST + 1);
  localparam int STALL_W = $clog2(STALL_MAX + 1);

  arb_state_t         state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [STALL_W-1:0] stall_cnt;

  logic               accept_p0;
  logic               end_burst_p0;
  logic               stall_rel_p0;
  logic [BEAT_W-1:0]  beat_nxt_p0;
  logic [STALL_W-1:0] stall_nxt_p0;
  logic [IDX_W-1:0]   next_ptr_p0;
  logic [ADDR_W-1:0]  owner_addr_p0;
  logic [DATA_W-1:0]  owner_data_p0;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .winner (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    req_ready = '0;
    if (state == ARB_GRANT) req_ready[owner] = 1'b1;
  end

  // Stage p0: owner beat selection and release decision
  assign accept_p0     = (state == ARB_GRANT) && req_valid[owner];
  assign owner_addr_p0 = req_addr[int'(owner)*ADDR_W +: ADDR_W];
  assign owner_data_p0 = req_data[int'(owner)*DATA_W +: DATA_W];
  assign beat_nxt_p0   = beat_cnt + BEAT_W'(1);
  assign stall_nxt_p0  = stall_cnt + STALL_W'(1);
  assign end_burst_p0  = req_last[owner] || (beat_nxt_p0 == BEAT_W'(MAX_BURST));
  assign stall_rel_p0  = (stall_nxt_p0 == STALL_W'(STALL_MAX));
  assign next_ptr_p0   = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);

  // Stage p1: registered RAM port, FSM and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      stall_cnt <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
      ram_en    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
    end else begin
      ram_en <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            state     <= ARB_GRANT;
            owner     <= pick_idx;
            grant_id  <= pick_idx;
            busy      <= 1'b1;
            beat_cnt  <= '0;
            stall_cnt <= '0;
          end
        end
        ARB_GRANT: begin
          if (accept_p0) begin
            ram_en    <= 1'b1;
            ram_addr  <= owner_addr_p0;
            ram_data  <= owner_data_p0;
            beat_cnt  <= beat_nxt_p0;
            stall_cnt <= '0;
            if (end_burst_p0) begin
              state  <= ARB_IDLE;
              busy   <= 1'b0;
              rr_ptr <= next_ptr_p0;
            end
          end else begin
            stall_cnt <= stall_nxt_p0;
            if (stall_rel_p0) begin
              state  <= ARB_IDLE;
              busy   <= 1'b0;
              rr_ptr <= next_ptr_p0;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_ram_wr_arbiter.sv
// Self-checking bench for debug_ram_wr_arbiter: vector table, scoreboard and burst corner cases.
module tb_debug_ram_wr_arbiter;

  localparam int N  = 2;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid, req_ready, req_last;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          busy;
  logic [0:0]    grant_id;

  logic          vld [N];
  logic          lst [N];
  logic [AW-1:0] adr [N];
  logic [DW-1:0] dat [N];

  always #5 clk = ~clk;

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = vld[i];
      req_last[i]           = lst[i];
      req_addr[i*AW +: AW]  = adr[i];
      req_data[i*DW +: DW]  = dat[i];
    end
  end

  debug_ram_wr_arbiter #(
    .N_REQ     (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_BURST (16),
    .STALL_MAX (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_last  (req_last),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            exp_gid;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
  } vec_t;

  int    checks = 0;
  int    fails  = 0;
  int    cyc    = 0;
  bit    mon_on = 1'b0;
  beat_t sbq  [$];
  beat_t wlog [$];
  int    wcyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor plus continuous ready/grant consistency.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && mon_on) begin
      if (req_ready != '0) begin
        check("ready_owner", 32'(req_ready), 32'(1) << grant_id);
        check("ready_busy", 32'(busy), 32'(1));
      end
      if (ram_en) begin
        wlog.push_back({ram_addr, ram_data});
        wcyc.push_back(cyc);
        if (sbq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", ram_addr, ram_data);
        end else begin
          e = sbq.pop_front();
          check("write_beat", 32'({ram_addr, ram_data}), 32'(e));
        end
      end
    end
  end

  task automatic send(input int id, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input int n, input bit last_end);
    int t;
    for (int b = 0; b < n; b++) begin
      t       = 0;
      vld[id] = 1'b1;
      adr[id] = a0 + AW'(b);
      dat[id] = d0 + DW'(b);
      lst[id] = last_end && (b == n - 1);
      do begin
        @(negedge clk);
        t++;
      end while (!req_ready[id] && t < 300);
      if (!req_ready[id]) begin
        checks++;
        fails++;
        $display("FAIL ready_timeout req%0d: no ready after %0d cycles, required a grant", id, t);
        vld[id] = 1'b0;
        lst[id] = 1'b0;
        return;
      end
      sbq.push_back({adr[id], dat[id]});
      @(posedge clk);
      #1;
    end
    vld[id] = 1'b0;
    lst[id] = 1'b0;
  endtask

  task automatic do_reset();
    mon_on = 1'b0;
    rst_n  = 1'b0;
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0;
      lst[i] = 1'b0;
      adr[i] = '0;
      dat[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sbq.delete();
    wlog.delete();
    wcyc.delete();
    mon_on = 1'b1;
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  endtask

  initial begin
    #200000;
    checks++;
    fails++;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    finish_test();
  end

  initial begin
    vec_t          tbl [4];
    logic [AW-1:0] order [4];
    int            waited;

    tbl[0] = '{0, 10'h005, 8'hA5, 0, 10'h005, 8'hA5};
    tbl[1] = '{1, 10'h3FF, 8'h5A, 1, 10'h3FF, 8'h5A};
    tbl[2] = '{0, 10'h000, 8'hFF, 0, 10'h000, 8'hFF};
    tbl[3] = '{1, 10'h2AA, 8'h00, 1, 10'h2AA, 8'h00};
    order  = '{10'h010, 10'h020, 10'h011, 10'h021};

    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0;
      lst[i] = 1'b0;
      adr[i] = '0;
      dat[i] = '0;
    end
    #12;
    check("rst_ram_en", 32'(ram_en), 32'(0));
    check("rst_ram_addr", 32'(ram_addr), 32'(0));
    check("rst_ram_data", 32'(ram_data), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_grant_id", 32'(grant_id), 32'(0));
    check("rst_req_ready", 32'(req_ready), 32'(0));
    do_reset();

    // Single-beat bursts: latency and release timing per vector.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      vld[tbl[i].id] = 1'b1;
      adr[tbl[i].id] = tbl[i].addr;
      dat[tbl[i].id] = tbl[i].data;
      lst[tbl[i].id] = 1'b1;
      @(negedge clk);
      check("tbl_no_write_t0", 32'(ram_en), 32'(0));
      @(negedge clk);
      check("tbl_ready_t1", 32'(req_ready[tbl[i].id]), 32'(1));
      check("tbl_busy_t1", 32'(busy), 32'(1));
      check("tbl_gid_t1", 32'(grant_id), 32'(tbl[i].exp_gid));
      if (req_ready[tbl[i].id]) sbq.push_back({tbl[i].addr, tbl[i].data});
      @(posedge clk);
      #1;
      vld[tbl[i].id] = 1'b0;
      lst[tbl[i].id] = 1'b0;
      @(negedge clk);
      check("tbl_en_t2", 32'(ram_en), 32'(1));
      check("tbl_addr_t2", 32'(ram_addr), 32'(tbl[i].exp_addr));
      check("tbl_data_t2", 32'(ram_data), 32'(tbl[i].exp_data));
      check("tbl_busy_t2", 32'(busy), 32'(0));
      @(negedge clk);
      check("tbl_en_t3", 32'(ram_en), 32'(0));
      check("tbl_gid_t3", 32'(grant_id), 32'(tbl[i].exp_gid));
    end
    check("tbl_sb_empty", 32'(sbq.size()), 32'(0));

    // Both requesters contend with single-beat bursts: 0,1,0,1 every 2 cycles.
    do_reset();
    @(posedge clk);
    #1;
    fork
      begin
        send(0, 10'h010, 8'h10, 1, 1'b1);
        send(0, 10'h011, 8'h11, 1, 1'b1);
      end
      begin
        send(1, 10'h020, 8'h20, 1, 1'b1);
        send(1, 10'h021, 8'h21, 1, 1'b1);
      end
    join
    repeat (3) @(negedge clk);
    check("rr_write_count", 32'(wlog.size()), 32'(4));
    for (int k = 0; k < 4 && k < wlog.size(); k++) check("rr_order", 32'(wlog[k].a), 32'(order[k]));
    for (int k = 1; k < 4 && k < wcyc.size(); k++) check("rr_spacing", 32'(wcyc[k] - wcyc[k-1]), 32'(2));

    // 20-beat burst: forced release after 16, then re-granted for the rest.
    do_reset();
    @(posedge clk);
    #1;
    send(1, 10'h100, 8'h40, 20, 1'b1);
    repeat (3) @(negedge clk);
    check("burst_write_count", 32'(wlog.size()), 32'(20));
    check("burst_sb_empty", 32'(sbq.size()), 32'(0));
    if (wlog.size() >= 17) begin
      check("burst_addr_16th", 32'(wlog[15].a), 32'(10'h10F));
      check("burst_addr_17th", 32'(wlog[16].a), 32'(10'h110));
      check("burst_stream_gap", 32'(wcyc[15] - wcyc[14]), 32'(1));
      check("burst_release_gap", 32'(wcyc[16] - wcyc[15]), 32'(2));
    end

    // Owner stalls after 3 beats; waiting requester 0 follows the stall release.
    do_reset();
    @(posedge clk);
    #1;
    send(1, 10'h200, 8'h60, 3, 1'b0);
    send(0, 10'h050, 8'h77, 1, 1'b1);
    repeat (3) @(negedge clk);
    check("stall_write_count", 32'(wlog.size()), 32'(4));
    if (wlog.size() >= 4) begin
      check("stall_next_owner_addr", 32'(wlog[3].a), 32'(10'h050));
      check("stall_release_gap", 32'(wcyc[3] - wcyc[2]), 32'(10));
    end

    // Non-owner holds valid through 30 cycles of a sparse burst from requester 0.
    do_reset();
    @(posedge clk);
    #1;
    waited = 0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          send(0, 10'h080 + AW'(k), 8'h80 + DW'(k), 1, k == 4);
          if (k < 4) begin
            repeat (6) @(posedge clk);
            #1;
          end
        end
      end
      begin
        @(posedge clk);
        #1;
        vld[1] = 1'b1;
        adr[1] = 10'h3C0;
        dat[1] = 8'h3C;
        lst[1] = 1'b1;
        do begin
          @(negedge clk);
          if (!req_ready[1]) waited++;
        end while (!req_ready[1] && waited < 100);
        if (req_ready[1]) begin
          sbq.push_back({adr[1], dat[1]});
          @(posedge clk);
          #1;
        end
        vld[1] = 1'b0;
        lst[1] = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check("bp_wait_cycles", 32'(waited), 32'(30));
    check("bp_write_count", 32'(wlog.size()), 32'(6));
    if (wlog.size() >= 6) check("bp_last_addr", 32'(wlog[5].a), 32'(10'h3C0));

    // Reset asserted in the cycle a beat is being accepted.
    do_reset();
    @(posedge clk);
    #1;
    vld[0] = 1'b1;
    adr[0] = 10'h0C0;
    dat[0] = 8'hC0;
    lst[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_ready_b1", 32'(req_ready[0]), 32'(1));
    if (req_ready[0]) sbq.push_back({adr[0], dat[0]});
    @(posedge clk);
    #1;
    adr[0] = 10'h0C1;
    dat[0] = 8'hC1;
    @(negedge clk);
    check("rstmid_ready_b2", 32'(req_ready[0]), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_ram_en", 32'(ram_en), 32'(0));
    check("rstmid_ram_addr", 32'(ram_addr), 32'(0));
    check("rstmid_ram_data", 32'(ram_data), 32'(0));
    check("rstmid_busy", 32'(busy), 32'(0));
    check("rstmid_ready", 32'(req_ready), 32'(0));
    check("rstmid_grant_id", 32'(grant_id), 32'(0));
    vld[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rstmid_write_count", 32'(wlog.size()), 32'(1));
    check("rstmid_sb_empty", 32'(sbq.size()), 32'(0));

    finish_test();
  end

endmodule
